casc_counter: RTL

CASC_COUNTER -- requirements
Module: casc_counter

---
 rtl/casc_counter_pkg.sv | 24 ++
 rtl/casc_stage.sv | 69 ++++++
 rtl/casc_counter.sv | 108 ++++++++++
 3 files changed

// File: rtl/casc_counter_pkg.sv
// rtl/casc_counter_pkg.sv - shared definitions for the cascaded counter
//
// Purpose: width helper, default hours/minutes/seconds terminal values and
//          the count-direction type used by casc_counter and casc_stage.
// Contents:
//    numofbits(n) - bits needed to index n items (minimum 1)
//    HMS_MAX      - default per-stage terminal values, index 0 = seconds
//    stage_dir_t  - DIR_DOWN = 0, DIR_UP = 1

package def;

   function automatic int numofbits(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Descending range so '{23,59,59} places seconds (59) at index 0.
   localparam int HMS_MAX [2:0] = '{23, 59, 59};

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } stage_dir_t;

endpackage

// File: rtl/casc_stage.sv
// rtl/casc_stage.sv - one stage of the cascaded counter
//
// Purpose: holds one stage value, detects its terminal value for the current
//          direction, steps up/down with wrap, and pulses carry on wrap.
// Ports:
//    clock, reset     - rising-edge clock, asynchronous active-low reset
//    i_clear          - synchronous clear (highest priority)
//    i_load           - write i_load_val (already range-checked by the top)
//    i_load_val       - value to load
//    i_step           - step this stage this cycle
//    i_dir            - count direction
//    o_val            - current stage value
//    o_terminal       - stage sits at its terminal value for i_dir
//    o_carry          - one-cycle pulse after the stage wrapped

module casc_stage
   import def::*;
#(
   parameter int W   = 6,
   parameter int MAX = 59
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_step,
   input  stage_dir_t   i_dir,
   output logic [W-1:0] o_val,
   output logic         o_terminal,
   output logic         o_carry
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] r_val;
   logic         r_carry;
   logic         w_term;

   assign w_term = (i_dir == DIR_UP) ? (r_val == MAX_V) : (r_val == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_val   <= '0;
         r_carry <= 1'b0;
      end else if (i_clear) begin
         r_val   <= '0;
         r_carry <= 1'b0;
      end else if (i_load) begin
         r_val   <= i_load_val;
         r_carry <= 1'b0;
      end else if (i_step) begin
         r_carry <= w_term;
         if (w_term)
            r_val <= (i_dir == DIR_UP) ? '0 : MAX_V;
         else if (i_dir == DIR_UP)
            r_val <= r_val + W'(1);
         else
            r_val <= r_val - W'(1);
      end else begin
         r_carry <= 1'b0;
      end
   end

   assign o_val      = r_val;
   assign o_terminal = w_term;
   assign o_carry    = r_carry;

endmodule

// File: rtl/casc_counter.sv
// rtl/casc_counter.sv - cascaded multi-stage up/down counter
//
// Purpose: NUM_STAGES counter stages chained so that a stage steps only when
//          every lower stage is at its terminal value; whole chain resolves in
//          one edge. Supports synchronous clear and range-checked stage load.
// Ports:
//    clock, reset  - rising-edge clock, asynchronous active-low reset
//    clear         - synchronous clear of all stages (highest priority)
//    tick          - count-step request (ignored while load is high)
//    up_down       - 1 = count up, 0 = count down
//    load          - load load_val into stage load_sel
//    load_sel      - stage index for load
//    load_val      - value to load
//    stage_val     - packed stage values, [0] = lowest stage
//    carry         - per-stage wrap pulse
//    wrap          - full-chain wrap pulse (= top stage carry)
//    load_err      - pulse when a load was rejected

module casc_counter
   import def::*;
#(
   parameter int NUM_STAGES                  = 3,
   parameter int W                           = 6,
   parameter int STAGE_MAX [NUM_STAGES-1:0]  = HMS_MAX
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               clear,
   input  logic                               tick,
   input  logic                               up_down,
   input  logic                               load,
   input  logic [numofbits(NUM_STAGES)-1:0]   load_sel,
   input  logic [W-1:0]                       load_val,
   output logic [NUM_STAGES-1:0][W-1:0]       stage_val,
   output logic [NUM_STAGES-1:0]              carry,
   output logic                               wrap,
   output logic                               load_err
);

   stage_dir_t              w_dir;
   logic                    w_load_ok;
   logic                    w_load_acc;
   logic                    w_tick_ok;
   logic [NUM_STAGES-1:0]   w_term;
   logic [NUM_STAGES-1:0]   w_en;
   logic                    r_load_err;

   assign w_dir = stage_dir_t'(up_down);

   // A load is valid only if load_sel names an existing stage and load_val
   // does not exceed that stage's terminal value; an out-of-range select
   // matches no iteration and is therefore rejected.
   always_comb begin
      w_load_ok = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if ((32'(load_sel) == k) && (32'(load_val) <= 32'(STAGE_MAX[k])))
            w_load_ok = 1'b1;
      end
   end

   assign w_load_acc = load & ~clear & w_load_ok;
   // Tick during a load is dropped, not deferred.
   assign w_tick_ok  = tick & ~load & ~clear;

   // Stage k is enabled when all stages below it are terminal; all enables
   // come straight from current register values, so no ripple delay.
   always_comb begin
      logic v_acc;
      v_acc = 1'b1;
      w_en  = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         w_en[k] = v_acc;
         v_acc   = v_acc & w_term[k];
      end
   end

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      logic w_ld;
      assign w_ld = w_load_acc & (32'(load_sel) == k);

      casc_stage #(
         .W   (W),
         .MAX (STAGE_MAX[k])
      ) u_stage (
         .clock      (clock),
         .reset      (reset),
         .i_clear    (clear),
         .i_load     (w_ld),
         .i_load_val (load_val),
         .i_step     (w_tick_ok & w_en[k]),
         .i_dir      (w_dir),
         .o_val      (stage_val[k]),
         .o_terminal (w_term[k]),
         .o_carry    (carry[k])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_load_err <= 1'b0;
      else
         r_load_err <= load & ~clear & ~w_load_ok;
   end

   assign load_err = r_load_err;
   assign wrap     = carry[NUM_STAGES-1];

endmodule
